// File: rtl/datapath_pkg.sv
// Shared datapath definitions: sequencing states and the default digit size
// used by the serial arithmetic blocks.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_DEF = 4;

endpackage

// File: rtl/digit_sub_slice.sv
// Combinational DIGIT-bit subtract slice: a + ~b + cin, with carry lookahead
// built from per-bit generate/propagate terms.
module digit_sub_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] diff,
    output logic             cout
);

    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] p;
    logic [DIGIT:0]   c;
    logic             acc;
    logic             pp;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // Each carry is expanded directly from g/p/cin rather than from the previous carry.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign diff = p ^ c[DIGIT-1:0];
    assign cout = c[DIGIT];

endmodule

// File: rtl/digit_serial_sub.sv
// Digit-serial unsigned subtractor A - B, one DIGIT-bit slice per clock, LSB first,
// with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready=1
//   RUN   | one digit per cycle through the slice, borrow chained via carry flop
//   DONE  | result presented, held until out_ready; may accept next pair directly
module digit_serial_sub
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_width_check
        $error("digit_serial_sub: WIDTH must be a multiple of DIGIT");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             load, step;
    logic [DIGIT-1:0] s_diff;
    logic             s_cout;

    digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .a   (a_sr[DIGIT-1:0]),
        .b   (b_sr[DIGIT-1:0]),
        .cin (carry),
        .diff(s_diff),
        .cout(s_cout)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b1;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sr  <= in_a;
                b_sr  <= in_b;
                carry <= 1'b1;
                cnt   <= '0;
            end else if (step) begin
                a_sr  <= a_sr >> DIGIT;
                b_sr  <= b_sr >> DIGIT;
                r_sr  <= (r_sr >> DIGIT) | (WIDTH'(s_diff) << (WIDTH - DIGIT));
                carry <= s_cout;
                if (cnt != LAST) cnt <= cnt + CW'(1);
            end
        end
    end

    // Carry only holds the final borrow once the last digit has been processed.
    assign out_diff   = r_sr;
    assign out_borrow = (state == DONE) & ~carry;

endmodule
